adder_seq_ctrl: RTL

Sequencing controller that performs a WIDTH-bit add/subtract by time-multiplexing one external 4-bit ripple-carry adder slice, one nibble per clock, LSB nibble first. It owns the operand/result registers and the inter-nibble carry register, and drives the slice's A/B/Cin inputs. It sits between a requesting unit (start/done handshake) and the shared 4-bit adder datapath.

---
 rtl/adder_seq_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl: sequences a WIDTH-bit add/subtract through one shared external 4-bit
// ripple-carry adder slice, one nibble per clock, least significant nibble first.
//
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   start, sub, A, B, Cin request and operands, sampled when not busy (IDLE or DONE)
//   busy                  high while nibbles are being processed
//   done                  one-cycle pulse when S/Cout/V are valid
//   S, Cout, V            registered result, carry out of the MSB slice, signed overflow
//   slice_A/B/Cin         drive to the external adder slice (zero outside RUN)
//   slice_S, slice_Cout   result returned by the external adder slice
module adder_seq_ctrl #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   sub,
    input  logic [4*NIBBLES-1:0]   A,
    input  logic [4*NIBBLES-1:0]   B,
    input  logic                   Cin,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   S,
    output logic                   Cout,
    output logic                   V,
    output logic [3:0]             slice_A,
    output logic [3:0]             slice_B,
    output logic                   slice_Cin,
    input  logic [3:0]             slice_S,
    input  logic                   slice_Cout
);

    localparam int unsigned WIDTH = 4 * NIBBLES;
    localparam int unsigned IdxW  = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IdxW-1:0]  LastIdx = IdxW'(NIBBLES - 1);
    localparam logic [WIDTH-1:0] NibMask = WIDTH'(4'hF);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic              carry_q, carry_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  s_q, s_d;
    logic              cout_q, cout_d;
    logic              v_q, v_d;

    // Bit offset of the active nibble.
    logic [IdxW+1:0]   sh;
    logic [WIDTH-1:0]  a_sh, b_sh;

    assign sh   = {idx_q, 2'b00};
    assign a_sh = a_q >> sh;
    assign b_sh = b_q >> sh;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        carry_d   = carry_q;
        a_d       = a_q;
        b_d       = b_q;
        s_d       = s_q;
        cout_d    = cout_q;
        v_d       = v_q;
        busy      = 1'b0;
        done      = 1'b0;
        slice_A   = 4'h0;
        slice_B   = 4'h0;
        slice_Cin = 1'b0;

        unique case (state_q)
            StRun: begin
                busy      = 1'b1;
                slice_A   = a_sh[3:0];
                slice_B   = b_sh[3:0];
                slice_Cin = carry_q;
                s_d       = (s_q & ~(NibMask << sh)) | (WIDTH'(slice_S) << sh);
                carry_d   = slice_Cout;
                if (idx_q == LastIdx) begin
                    state_d = StDone;
                    cout_d  = slice_Cout;
                    // b_q already holds ~B in sub mode, so this is the usual add-overflow rule.
                    v_d     = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice_S[3] != a_q[WIDTH-1]);
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StIdle, StDone: begin
                done    = (state_q == StDone);
                state_d = StIdle;
                if (start) begin
                    state_d = StRun;
                    a_d     = A;
                    b_d     = sub ? ~B : B;
                    carry_d = sub ? 1'b1 : Cin;
                    s_d     = '0;
                    idx_d   = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            v_q     <= v_d;
        end
    end

    assign S    = s_q;
    assign Cout = cout_q;
    assign V    = v_q;

endmodule
